// File: rtl/nn_deltabp_pkg.sv
// Shared sizing helpers and sign encoding for the polar delta back-prop layer.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package nn_deltabp_pkg;

  // Bitstream sign encoding: a set sign bit marks a negative unary pulse.
  localparam logic SIGN_POS = 1'b0;
  localparam logic SIGN_NEG = 1'b1;

  // Width needed to count 0..n product terms in a single cycle.
  function automatic int pop_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Signed accumulator width. It must hold acc + P - Q before the clamp,
  // which spans +/-(n + n_carry), so one sign bit on top of the magnitude.
  function automatic int acc_w(input int n, input int n_carry);
    return $clog2(n + n_carry + 1) + 1;
  endfunction

endpackage

// File: rtl/nn_deltabp_chan.sv
// Single channel: signed popcount of delta*alpha terms, saturating carry accumulator, zp-gated unary output.
// Latency: 1 cycle, outputs registered from the current cycle's inputs.
// Backpressure: none; r_condition=0 freezes the accumulator and forces delta_out low.
//
// Ports: clk/rst (async active-high), r_condition (stream valid),
//        delta/sign_delta (shared next-layer deltas), alpha/sign_alpha (this
//        channel's weights), zp (derivative gate), delta_out/sign_out (unary
//        delta stream), sat (sticky clamp flag).
module nn_deltabp_chan
  import nn_deltabp_pkg::*;
#(
  parameter int N         = 3,
  parameter int N_CARRY   = 2,
  parameter int GATE_HOLD = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r_condition,
  input  logic [N-1:0] delta,
  input  logic [N-1:0] sign_delta,
  input  logic [N-1:0] alpha,
  input  logic [N-1:0] sign_alpha,
  input  logic         zp,
  output logic         delta_out,
  output logic         sign_out,
  output logic         sat
);

  localparam int PW = pop_w(N);
  localparam int AW = acc_w(N, N_CARRY);
  // One extra bit so the +/-1 consume step never wraps, even at the extremes.
  localparam int TW = AW + 1;
  localparam logic signed [TW-1:0] LIM = TW'(N_CARRY);

  logic signed [AW-1:0] acc;
  logic        [PW-1:0] pos_cnt;
  logic        [PW-1:0] neg_cnt;
  logic signed [TW-1:0] temp;
  logic signed [TW-1:0] after;
  logic signed [TW-1:0] clamped;
  logic                 clip;
  logic                 emit;
  logic                 neg;
  logic                 consume;
  logic                 out_bit;

  // Count positive and negative product terms separately; equal counts cancel.
  always_comb begin
    pos_cnt = '0;
    neg_cnt = '0;
    for (int j = 0; j < N; j++) begin
      if (delta[j] && alpha[j]) begin
        if (sign_delta[j] ^ sign_alpha[j]) neg_cnt = neg_cnt + PW'(1);
        else                               pos_cnt = pos_cnt + PW'(1);
      end
    end
  end

  always_comb begin
    temp = TW'(acc) + TW'(pos_cnt) - TW'(neg_cnt);
    neg  = temp[TW-1];
    emit = r_condition && (temp != '0);
    // In hold mode a gated-off pulse stays in the accumulator until zp opens.
    consume = (GATE_HOLD != 0) ? (emit && zp) : emit;
    out_bit = emit && zp;

    after = temp;
    if (consume) after = neg ? (temp + TW'(1)) : (temp - TW'(1));

    clamped = after;
    clip    = 1'b0;
    if (after > LIM) begin
      clamped = LIM;
      clip    = 1'b1;
    end else if (after < -LIM) begin
      clamped = -LIM;
      clip    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      delta_out <= 1'b0;
      sign_out  <= SIGN_POS;
      sat       <= 1'b0;
    end else begin
      delta_out <= out_bit;
      if (r_condition) begin
        acc <= AW'(clamped);
        if (clip) sat <= 1'b1;
      end
      // Sign is only meaningful alongside a pulse, so it holds otherwise.
      if (out_bit) sign_out <= neg ? SIGN_NEG : SIGN_POS;
    end
  end

endmodule

// File: rtl/nn_deltabp_polar_multi.sv
// Layer-wide polar delta back-prop: M independent channels sharing the next-layer delta streams.
// Latency: 1 cycle from inputs to delta_out/SIGN_out/sat.
// Backpressure: none; R_condition=0 freezes every channel and forces delta_out to 0.
//
// Ports: CLK, INIT (async active-high), R_condition, delta/SIGN_delta [N],
//        alpha/SIGN_alpha [M*N] (channel i at [i*N +: N]), zp [M],
//        delta_out/SIGN_out/sat [M].
module nn_deltabp_polar_multi
  import nn_deltabp_pkg::*;
#(
  parameter int N         = 3,
  parameter int M         = 4,
  parameter int N_CARRY   = 2,
  parameter int GATE_HOLD = 0
) (
  input  logic           CLK,
  input  logic           INIT,
  input  logic           R_condition,
  input  logic [N-1:0]   delta,
  input  logic [N-1:0]   SIGN_delta,
  input  logic [M*N-1:0] alpha,
  input  logic [M*N-1:0] SIGN_alpha,
  input  logic [M-1:0]   zp,
  output logic [M-1:0]   delta_out,
  output logic [M-1:0]   SIGN_out,
  output logic [M-1:0]   sat
);

  // A zero carry limit would make the accumulator unable to hold any excess.
  if (N_CARRY < 1) begin : g_bad_carry
    $error("nn_deltabp_polar_multi: N_CARRY must be >= 1");
  end
  if (N < 1 || M < 1) begin : g_bad_dims
    $error("nn_deltabp_polar_multi: N and M must be >= 1");
  end

  for (genvar i = 0; i < M; i++) begin : g_chan
    nn_deltabp_chan #(
      .N         (N),
      .N_CARRY   (N_CARRY),
      .GATE_HOLD (GATE_HOLD)
    ) u_chan (
      .clk         (CLK),
      .rst         (INIT),
      .r_condition (R_condition),
      .delta       (delta),
      .sign_delta  (SIGN_delta),
      .alpha       (alpha[i*N +: N]),
      .sign_alpha  (SIGN_alpha[i*N +: N]),
      .zp          (zp[i]),
      .delta_out   (delta_out[i]),
      .sign_out    (SIGN_out[i]),
      .sat         (sat[i])
    );
  end

endmodule

// File: tb/tb_nn_deltabp_polar_multi.sv
// Bench for the polar delta layer: a drop-mode and a hold-mode instance share stimulus.
// Expected outputs per cycle come from a hand-derived vector table via a scoreboard queue.
// Also covers async reset mid-run, reset state and the R_condition freeze.
module tb_nn_deltabp_polar_multi;

  localparam int N = 3;
  localparam int M = 4;

  logic           CLK;
  logic           INIT;
  logic           R_condition;
  logic [N-1:0]   delta;
  logic [N-1:0]   SIGN_delta;
  logic [M*N-1:0] alpha;
  logic [M*N-1:0] SIGN_alpha;
  logic [M-1:0]   zp;
  logic [M-1:0]   dout0, sout0, sat0;
  logic [M-1:0]   dout1, sout1, sat1;

  nn_deltabp_polar_multi #(.N(N), .M(M), .N_CARRY(2), .GATE_HOLD(0)) dut0 (
    .CLK(CLK), .INIT(INIT), .R_condition(R_condition),
    .delta(delta), .SIGN_delta(SIGN_delta), .alpha(alpha), .SIGN_alpha(SIGN_alpha),
    .zp(zp), .delta_out(dout0), .SIGN_out(sout0), .sat(sat0)
  );

  nn_deltabp_polar_multi #(.N(N), .M(M), .N_CARRY(2), .GATE_HOLD(1)) dut1 (
    .CLK(CLK), .INIT(INIT), .R_condition(R_condition),
    .delta(delta), .SIGN_delta(SIGN_delta), .alpha(alpha), .SIGN_alpha(SIGN_alpha),
    .zp(zp), .delta_out(dout1), .SIGN_out(sout1), .sat(sat1)
  );

  typedef struct {
    logic           r;
    logic [N-1:0]   d;
    logic [N-1:0]   sd;
    logic [M*N-1:0] a;
    logic [M*N-1:0] sa;
    logic [M-1:0]   z;
    logic [M-1:0]   do0, so0, st0;
    logic [M-1:0]   do1, so1, st1;
  } vec_t;

  typedef struct {
    logic [M-1:0] do0, so0, st0;
    logic [M-1:0] do1, so1, st1;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec;
  int   n_bad;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic chk(input string name, input int idx, input logic [M-1:0] act,
                     input logic [M-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec%0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  // Table entry where both gating modes must behave identically.
  task automatic add(input logic r, input logic [N-1:0] d, input logic [N-1:0] sd,
                     input logic [M*N-1:0] a, input logic [M*N-1:0] sa,
                     input logic [M-1:0] z, input logic [M-1:0] e_do,
                     input logic [M-1:0] e_so, input logic [M-1:0] e_st);
    vec_t v;
    v.r = r; v.d = d; v.sd = sd; v.a = a; v.sa = sa; v.z = z;
    v.do0 = e_do; v.so0 = e_so; v.st0 = e_st;
    v.do1 = e_do; v.so1 = e_so; v.st1 = e_st;
    tbl.push_back(v);
  endtask

  // Table entry where drop mode (0) and hold mode (1) diverge.
  task automatic add2(input logic r, input logic [N-1:0] d, input logic [N-1:0] sd,
                      input logic [M*N-1:0] a, input logic [M*N-1:0] sa,
                      input logic [M-1:0] z,
                      input logic [M-1:0] e_do0, input logic [M-1:0] e_so0,
                      input logic [M-1:0] e_st0, input logic [M-1:0] e_do1,
                      input logic [M-1:0] e_so1, input logic [M-1:0] e_st1);
    vec_t v;
    v.r = r; v.d = d; v.sd = sd; v.a = a; v.sa = sa; v.z = z;
    v.do0 = e_do0; v.so0 = e_so0; v.st0 = e_st0;
    v.do1 = e_do1; v.so1 = e_so1; v.st1 = e_st1;
    tbl.push_back(v);
  endtask

  // Drive one vector (just after a rising edge), queue its expectation,
  // then compare one time unit after the next rising edge.
  task automatic apply(input int i);
    exp_t e;
    R_condition = tbl[i].r;
    delta       = tbl[i].d;
    SIGN_delta  = tbl[i].sd;
    alpha       = tbl[i].a;
    SIGN_alpha  = tbl[i].sa;
    zp          = tbl[i].z;
    e.do0 = tbl[i].do0; e.so0 = tbl[i].so0; e.st0 = tbl[i].st0;
    e.do1 = tbl[i].do1; e.so1 = tbl[i].so1; e.st1 = tbl[i].st1;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard vec%0d: got empty queue expected entry", i);
    end else begin
      e = sb.pop_front();
      chk("delta_out_m0", i, dout0, e.do0);
      chk("sign_out_m0",  i, sout0, e.so0);
      chk("sat_m0",       i, sat0,  e.st0);
      chk("delta_out_m1", i, dout1, e.do1);
      chk("sign_out_m1",  i, sout1, e.so1);
      chk("sat_m1",       i, sat1,  e.st1);
    end
  endtask

  task automatic chk_reset(input int tag);
    chk("rst_delta_out_m0", tag, dout0, 4'b0000);
    chk("rst_sign_out_m0",  tag, sout0, 4'b0000);
    chk("rst_sat_m0",       tag, sat0,  4'b0000);
    chk("rst_delta_out_m1", tag, dout1, 4'b0000);
    chk("rst_sign_out_m1",  tag, sout1, 4'b0000);
    chk("rst_sat_m1",       tag, sat1,  4'b0000);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // 0-3: ch0 +3 per cycle. First cycle lands exactly on +2 (no clamp);
    // from the second cycle temp-1 = 4 is clamped, so sat[0] rises then.
    add(1'b1, 3'b111, 3'b000, 12'h007, 12'h000, 4'hF, 4'h1, 4'h0, 4'h0);
    add(1'b1, 3'b111, 3'b000, 12'h007, 12'h000, 4'hF, 4'h1, 4'h0, 4'h1);
    add(1'b1, 3'b111, 3'b000, 12'h007, 12'h000, 4'hF, 4'h1, 4'h0, 4'h1);
    add(1'b1, 3'b111, 3'b000, 12'h007, 12'h000, 4'hF, 4'h1, 4'h0, 4'h1);
    // 4: after the mid-run reset, zero inputs must emit nothing (acc cleared).
    add(1'b1, 3'b000, 3'b000, 12'h000, 12'h000, 4'hF, 4'h0, 4'h0, 4'h0);
    // 5-6: P=2, Q=1 -> one positive pulse per cycle, acc back to 0.
    add(1'b1, 3'b111, 3'b010, 12'h007, 12'h000, 4'hF, 4'h1, 4'h0, 4'h0);
    add(1'b1, 3'b111, 3'b010, 12'h007, 12'h000, 4'hF, 4'h1, 4'h0, 4'h0);
    // 7-8: ch1 negative weights, one-hot delta -> negative pulse each cycle.
    add(1'b1, 3'b001, 3'b000, 12'h038, 12'h038, 4'hF, 4'h2, 4'h2, 4'h0);
    add(1'b1, 3'b001, 3'b000, 12'h038, 12'h038, 4'hF, 4'h2, 4'h2, 4'h0);
    // 9-11: ch2 +2/cycle and ch3 -2/cycle together; both clamp on the 3rd.
    add(1'b1, 3'b011, 3'b000, 12'hFC0, 12'hE00, 4'hF, 4'hC, 4'hA, 4'h0);
    add(1'b1, 3'b011, 3'b000, 12'hFC0, 12'hE00, 4'hF, 4'hC, 4'hA, 4'h0);
    add(1'b1, 3'b011, 3'b000, 12'hFC0, 12'hE00, 4'hF, 4'hC, 4'hA, 4'hC);
    // 12-14: stored +/-2 drain as two more pulses each, then silence.
    add(1'b1, 3'b000, 3'b000, 12'h000, 12'h000, 4'hF, 4'hC, 4'hA, 4'hC);
    add(1'b1, 3'b000, 3'b000, 12'h000, 12'h000, 4'hF, 4'hC, 4'hA, 4'hC);
    add(1'b1, 3'b000, 3'b000, 12'h000, 12'h000, 4'hF, 4'h0, 4'hA, 4'hC);
    // 15-17: +1 on ch0 and ch1 while their zp is low, zp opens two cycles
    // later. Drop mode loses the pulses; hold mode emits them once zp=1,
    // which also flips ch1's held negative sign to positive.
    add(1'b1, 3'b001, 3'b000, 12'h009, 12'h000, 4'hC, 4'h0, 4'hA, 4'hC);
    add(1'b1, 3'b000, 3'b000, 12'h000, 12'h000, 4'hC, 4'h0, 4'hA, 4'hC);
    add2(1'b1, 3'b000, 3'b000, 12'h000, 12'h000, 4'hF,
         4'h0, 4'hA, 4'hC, 4'h3, 4'h8, 4'hC);
    // 18-24: ch0 reaches +2, then 3 frozen cycles with active inputs (no
    // pulse, no clamp), then the same drain an unfrozen run would give.
    add2(1'b1, 3'b111, 3'b000, 12'h007, 12'h000, 4'hF, 4'h1, 4'hA, 4'hC, 4'h1, 4'h8, 4'hC);
    add2(1'b0, 3'b111, 3'b000, 12'h007, 12'h000, 4'hF, 4'h0, 4'hA, 4'hC, 4'h0, 4'h8, 4'hC);
    add2(1'b0, 3'b111, 3'b000, 12'h007, 12'h000, 4'hF, 4'h0, 4'hA, 4'hC, 4'h0, 4'h8, 4'hC);
    add2(1'b0, 3'b111, 3'b000, 12'h007, 12'h000, 4'hF, 4'h0, 4'hA, 4'hC, 4'h0, 4'h8, 4'hC);
    add2(1'b1, 3'b000, 3'b000, 12'h000, 12'h000, 4'hF, 4'h1, 4'hA, 4'hC, 4'h1, 4'h8, 4'hC);
    add2(1'b1, 3'b000, 3'b000, 12'h000, 12'h000, 4'hF, 4'h1, 4'hA, 4'hC, 4'h1, 4'h8, 4'hC);
    add2(1'b1, 3'b000, 3'b000, 12'h000, 12'h000, 4'hF, 4'h0, 4'hA, 4'hC, 4'h0, 4'h8, 4'hC);
    // 25: P=1, Q=1 cancel with acc=0 -> nothing.
    add2(1'b1, 3'b011, 3'b010, 12'h003, 12'h000, 4'hF, 4'h0, 4'hA, 4'hC, 4'h0, 4'h8, 4'hC);

    // Reset state, then release reset between edges.
    INIT        = 1'b1;
    R_condition = 1'b0;
    delta       = '0;
    SIGN_delta  = '0;
    alpha       = '0;
    SIGN_alpha  = '0;
    zp          = '0;
    #2;
    chk_reset(-1);
    #1;
    INIT = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 4; i++) apply(i);

    // Async reset mid-cycle with ch0 holding +2 and sat[0] set.
    #3;
    INIT = 1'b1;
    #1;
    chk_reset(-2);
    #2;
    INIT = 1'b0;

    for (int i = 4; i < tbl.size(); i++) apply(i);

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
